// File: rtl/speed_cmd_if.sv
// Link between the serial speed-command receiver and its neighbours: the controller's
// serial bit clock/data on one side, the registered command for the PWM stage on the other.
interface speed_cmd_if;
  logic       f_en;
  logic       freq;
  logic [3:0] speed;
  logic       dir;
  logic       run;
  logic       upd;
  logic       err;
  logic [7:0] err_cnt;
  logic       stale;

  modport master (
    output f_en, freq,
    input  speed, dir, run, upd, err, err_cnt, stale
  );

  modport slave (
    input  f_en, freq,
    output speed, dir, run, upd, err, err_cnt, stale
  );
endinterface

// File: rtl/speed_cmd_rx.sv
// Serial speed-command receiver: synchronises the controller bit clock and data, hunts for
// the 1010 sync word, checks even parity and drives a held speed/dir/run command with a watchdog.
module speed_cmd_rx #(
  parameter int TIMEOUT = 4096,
  parameter int WDOG    = 1000000
) (
  input logic        clk,
  input logic        rst,
  speed_cmd_if.slave bus
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam int WD_W  = $clog2(WDOG + 1);

  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_PRE = GAP_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WDOG);
  localparam logic [3:0]       SYNC_WORD = 4'b1010;
  localparam logic [2:0]       LAST_BIT  = 3'd6;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t state, state_nx;

  // Input synchroniser and edge detector.
  logic f_en_s1, f_en_s2, f_en_q;
  logic freq_s1, freq_s2;
  logic acc_q;
  logic bit_q;

  // Frame assembly.
  logic [2:0] hist, hist_nx;
  logic [3:0] sync_shift;
  logic [5:0] data_sr, data_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [6:0] frame;
  logic       frame_ok, frame_bad, to_err;

  // Inter-bit gap and loss-of-link timers.
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_hit;
  logic [WD_W-1:0]  wdog_cnt;

  // Registered command outputs.
  logic [3:0] speed_q;
  logic       dir_q, run_q, upd_q, err_q, stale_q;
  logic [7:0] err_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      f_en_s1 <= 1'b0;
      f_en_s2 <= 1'b0;
      f_en_q  <= 1'b0;
      freq_s1 <= 1'b0;
      freq_s2 <= 1'b0;
      acc_q   <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      f_en_s1 <= bus.f_en;
      f_en_s2 <= f_en_s1;
      f_en_q  <= f_en_s2;
      freq_s1 <= bus.freq;
      freq_s2 <= freq_s1;
      acc_q   <= f_en_s2 & ~f_en_q;
      bit_q   <= freq_s2;
    end
  end

  // gap_hit pulses once, in the cycle the counter sits at TIMEOUT; an accept always wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_cnt <= '0;
      gap_hit <= 1'b0;
    end else if (acc_q) begin
      gap_cnt <= '0;
      gap_hit <= 1'b0;
    end else begin
      if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
      gap_hit <= (gap_cnt == GAP_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= HUNT;
      hist    <= '0;
      data_sr <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      hist    <= hist_nx;
      data_sr <= data_nx;
      bit_cnt <= bit_cnt_nx;
    end
  end

  // The stored three bits plus the incoming bit form the 4-bit sliding sync window.
  assign sync_shift = {hist, bit_q};
  assign frame      = {data_sr, bit_q};

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    hist_nx    = hist;
    data_nx    = data_sr;
    bit_cnt_nx = bit_cnt;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    to_err     = 1'b0;

    unique case (state)
      HUNT: begin
        if (acc_q) begin
          hist_nx = sync_shift[2:0];
          if (sync_shift == SYNC_WORD) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end
        end else if (gap_hit) begin
          hist_nx = '0;
        end
      end

      DATA: begin
        if (acc_q) begin
          if (bit_cnt == LAST_BIT) begin
            frame_ok  = ~^frame;
            frame_bad = ^frame;
            state_nx  = HUNT;
            hist_nx   = '0;
          end else begin
            data_nx    = {data_sr[4:0], bit_q};
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end else if (gap_hit) begin
          to_err   = 1'b1;
          hist_nx  = '0;
          state_nx = HUNT;
        end
      end

      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_cnt <= '0;
    end else if (frame_ok) begin
      wdog_cnt <= '0;
    end else if (wdog_cnt != WD_MAX) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  // A valid frame takes precedence over a watchdog expiry landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      speed_q   <= '0;
      dir_q     <= 1'b0;
      run_q     <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      stale_q   <= 1'b1;
    end else begin
      upd_q <= frame_ok;
      err_q <= frame_bad | to_err;

      if ((frame_bad | to_err) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;

      if (frame_ok) begin
        dir_q   <= frame[6];
        run_q   <= frame[5];
        speed_q <= frame[4:1];
        stale_q <= 1'b0;
      end else if (wdog_cnt == WD_MAX) begin
        run_q   <= 1'b0;
        speed_q <= '0;
        stale_q <= 1'b1;
      end
    end
  end

  assign bus.speed   = speed_q;
  assign bus.dir     = dir_q;
  assign bus.run     = run_q;
  assign bus.upd     = upd_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.stale   = stale_q;

endmodule

// File: doc/speed_cmd_rx.md
# speed_cmd_rx

Serial command receiver that sits directly upstream of the sine-PWM phase driver. It samples the controller's bit clock (`f_en`) and data (`freq`) in the `clk` domain. It hunts for a fixed sync pattern and checks parity over each command frame. It then presents a registered `speed`/`dir`/`run` command to the PWM stage, with an update strobe, error reporting and a loss-of-link watchdog that forces a safe stop.

## Interface
- `TIMEOUT`, 4096: maximum `clk` cycles allowed between consecutive accepted bit edges before the partial frame is discarded.
- `WDOG`, 1000000: `clk` cycles without a valid frame before the command is forced to stop.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `f_en`  in  1  serial bit clock from the controller, asynchronous to `clk`; data is valid on its rising edge.
- `freq`  in  1  serial data, asynchronous; sampled together with `f_en`.
- `speed`  out  4  commanded speed step for the PWM stage.
- `dir`  out  1  commanded rotation direction.
- `run`  out  1  commanded enable.
- `upd`  out  1  one-cycle pulse when `speed`/`dir`/`run` are loaded from a valid frame.
- `err`  out  1  one-cycle pulse on a parity failure or a mid-frame timeout.
- `err_cnt`  out  8  saturating error count.
- `stale`  out  1  high from reset until the first valid frame, and whenever the watchdog has expired.

## Operation
- **Input synchronisation.** `f_en` and `freq` each pass through two flops. A bit is accepted in the cycle where the synchronised `f_en` is 1 and its previous registered value is 0. The data value is the synchronised `freq` of that same cycle.
- **Frame format.** 11 bits, in order:
  - sync `1,0,1,0`;
  - `dir`;
  - `run`;
  - `speed[3]`, `speed[2]`, `speed[1]`, `speed[0]`;
  - parity `p`.
- **Parity rule.** Even parity: the frame is valid when `dir^run^speed[3]^speed[2]^speed[1]^speed[0]^p == 0`.
- **State HUNT.**
  - A 4-bit sliding register shifts in each accepted bit, MSB-first.
  - On the accept that makes the register equal `4'b1010`, go to DATA with the bit counter at 0.
  - Sync bits are not re-counted; overlapping prefixes are allowed (e.g. `1,1,0,1,0` syncs on the fifth bit).
- **State DATA.**
  - Shift in 7 bits; the bit counter runs 0..6.
  - On the 7th accept, evaluate parity.
  - Valid frame: load `dir`, `run`, `speed` and pulse `upd`.
  - Invalid frame: pulse `err`, increment `err_cnt`, leave the outputs unchanged.
  - In both cases return to HUNT with the sliding register cleared to 0.
- **Bit timeout.** A gap counter clears on every accepted bit and otherwise increments, saturating. When it reaches `TIMEOUT`:
  - In HUNT: clear the sliding register, with no error. Sync bits must therefore be contiguous in time.
  - In DATA: pulse `err`, increment `err_cnt`, clear the sliding register, go to HUNT.
- **Watchdog.**
  - The watchdog counter clears on every valid frame and otherwise increments, saturating at `WDOG`.
  - On reaching `WDOG`: `run` is forced to 0, `speed` is forced to 0, `stale` goes to 1, and `dir` is held.
  - No `upd` pulse is generated for the forced stop.
- **Error count.** `err_cnt` saturates at 255 and clears only on reset.
- **Simultaneous events.**
  - A valid frame completing in the same cycle the watchdog expires: the frame wins. Outputs load, `stale` goes to 0, the watchdog clears.
  - A bit accepted in the same cycle the gap counter would reach `TIMEOUT`: the accept wins and there is no timeout.
- **Reset** (`rst`=0 at a rising edge):
  - `speed`=0, `dir`=0, `run`=0, `upd`=0, `err`=0, `err_cnt`=0, `stale`=1;
  - state HUNT, sliding register 0, synchroniser flops 0, gap counter 0, watchdog counter 0.
  - Reset mid-frame discards the partial frame.

## Timing
- **Frame-to-output latency.** Let edge E be the first `clk` rising edge that samples `f_en`=1 for the parity bit.
  - `speed`/`dir`/`run`, `stale`, `upd`=1 (valid frame) or `err`=1 and the `err_cnt` increment (invalid frame) are visible after edge E+3: two synchroniser edges plus one register edge.
  - `upd` and `err` are high for exactly one cycle and are never high together.
- **Minimum bit timing.** `f_en` high and low phases must each last at least 2 `clk` cycles. Faster input is outside the operating range.
- **Timeout error.** The `err` pulse appears the cycle after the gap counter reaches `TIMEOUT`.
- **Watchdog forcing.** The forced stop appears the cycle after the watchdog counter reaches `WDOG`.
- **Held outputs.** `speed`, `dir` and `run` change only on a valid frame, on watchdog expiry, or on reset.

## Test plan
All scenarios use `TIMEOUT`=16, `WDOG`=200, and `f_en` periods of 8 `clk` cycles.

1. Reset, then send frame `1010 1 1 0101 0` -> a single `upd` pulse; `speed`=5, `dir`=1, `run`=1, `stale`=0, `err_cnt`=0.
2. Send frame `1010 1 1 0101 1` (bad parity) -> a single `err` pulse, `err_cnt`=1; `speed`/`dir`/`run` unchanged; no `upd`.
3. Send `1 1 1010 0 1 1111 1` (leading noise) -> sync found on the sliding match; `speed`=15, `dir`=0, `run`=1, `upd` pulse.
4. Send sync plus 3 data bits, then hold `f_en` low for 20 cycles -> `err` pulse, `err_cnt` incremented; a following complete valid frame is accepted normally.
5. After a valid `run`=1 frame, send nothing for 200+ cycles -> `run`=0, `speed`=0, `stale`=1, `dir` held, no `upd`. The next valid frame restores the outputs and sets `stale`=0.
6. Send 260 bad-parity frames -> `err_cnt` stops at 255. Then assert `rst`=0 mid-frame -> all outputs return to their reset values, and a following valid frame is decoded from HUNT.
